// File: rtl/dds_wave_gen.sv
// DDS front end: phase accumulator, ROM address generation, waveform select and
// amplitude scaling ahead of the AD9708 DAC. Config changes in RUN are deferred to the next wrap.
module dds_wave_gen #(
  parameter int ACC_W   = 32,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ACC_W-1:0]  cfg_fword,
  input  logic [ADDR_W-1:0] cfg_pword,
  input  logic [7:0]        cfg_amp,
  input  logic [1:0]        cfg_mode,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              da_clk,
  output logic [DATA_W-1:0] da_data,
  output logic              wrap_pulse
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] PEND = 2'd2;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0]        state;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  fword, sh_fword;
  logic [ADDR_W-1:0] pword, sh_pword;
  logic [7:0]        amp, sh_amp;
  logic [1:0]        mode, sh_mode;

  logic              accept;
  logic              upd;
  logic [ACC_W:0]    sum;
  logic              carry;

  assign cfg_ready = (state != PEND);
  assign accept    = cfg_valid & cfg_ready;
  assign upd       = (state != IDLE) & en;
  assign sum       = {1'b0, acc} + {1'b0, fword};
  assign carry     = sum[ACC_W];
  assign da_clk    = ~clk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      fword      <= '0;
      pword      <= '0;
      amp        <= 8'hFF;
      mode       <= 2'd0;
      sh_fword   <= '0;
      sh_pword   <= '0;
      sh_amp     <= '0;
      sh_mode    <= '0;
      wrap_pulse <= 1'b0;
    end else begin
      wrap_pulse <= upd & carry;
      if (upd) acc <= sum[ACC_W-1:0];
      case (state)
        IDLE: begin
          if (accept) begin
            fword <= cfg_fword;
            pword <= cfg_pword;
            amp   <= cfg_amp;
            mode  <= cfg_mode;
            acc   <= '0;
          end
          if (en) state <= RUN;
        end
        RUN: begin
          if (!en) begin
            // Stopping: nothing to defer to, so a config accepted now goes live directly.
            state <= IDLE;
            if (accept) begin
              fword <= cfg_fword;
              pword <= cfg_pword;
              amp   <= cfg_amp;
              mode  <= cfg_mode;
            end
          end else if (accept) begin
            sh_fword <= cfg_fword;
            sh_pword <= cfg_pword;
            sh_amp   <= cfg_amp;
            sh_mode  <= cfg_mode;
            state    <= PEND;
          end
        end
        PEND: begin
          if (!en || carry) begin
            fword <= sh_fword;
            pword <= sh_pword;
            amp   <= sh_amp;
            mode  <= sh_mode;
            state <= en ? RUN : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 0 is rd_addr itself; stages 1..ROM_LAT line up with rd_data.
  logic [ADDR_W-1:0] a_pipe    [ROM_LAT+1];
  logic [1:0]        mode_pipe [ROM_LAT+1];
  logic [7:0]        amp_pipe  [ROM_LAT+1];
  logic [ROM_LAT:0]  v_pipe;

  assign rd_addr = a_pipe[0];

  logic [ADDR_W-1:0]        a_d;
  logic [ADDR_W-1:0]        tri_base;
  logic [DATA_W-1:0]        sample;
  logic signed [DATA_W-1:0] s;
  logic [8:0]               gain;
  logic signed [DATA_W+9:0] prod;
  logic signed [DATA_W+9:0] shifted;
  logic [DATA_W-1:0]        scaled;

  always_comb begin
    a_d      = a_pipe[ROM_LAT];
    tri_base = a_d << 1;
    sample   = rd_data;
    case (mode_pipe[ROM_LAT])
      2'd0:    sample = rd_data;
      2'd1:    sample = a_d[ADDR_W-1] ? '1 : '0;
      2'd2:    sample = DATA_W'(a_d);
      default: sample = DATA_W'(a_d[ADDR_W-1] ? ~tri_base : tri_base);
    endcase
    s       = $signed(sample - MID);
    gain    = {1'b0, amp_pipe[ROM_LAT]} + 9'd1;
    prod    = $signed({{10{s[DATA_W-1]}}, s}) * $signed({{(DATA_W+1){1'b0}}, gain});
    shifted = prod >>> 8;
    scaled  = MID + shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i <= ROM_LAT; i++) begin
        a_pipe[i]    <= '0;
        mode_pipe[i] <= '0;
        amp_pipe[i]  <= '0;
      end
      v_pipe  <= '0;
      da_data <= MID;
    end else begin
      if (upd) begin
        a_pipe[0]    <= acc[ACC_W-1 -: ADDR_W] + pword;
        mode_pipe[0] <= mode;
        amp_pipe[0]  <= amp;
      end
      v_pipe[0] <= upd;
      for (int i = 1; i <= ROM_LAT; i++) begin
        a_pipe[i]    <= a_pipe[i-1];
        mode_pipe[i] <= mode_pipe[i-1];
        amp_pipe[i]  <= amp_pipe[i-1];
        v_pipe[i]    <= v_pipe[i-1] & en;
      end
      da_data <= (en & v_pipe[ROM_LAT]) ? scaled : MID;
    end
  end

endmodule

// File: tb/tb_dds_wave_gen.sv
// Randomised bench for dds_wave_gen: a history-based reference model predicts address,
// wrap, ready and DAC sample every cycle from the behavioural rules.
module tb_dds_wave_gen;
  localparam int L = 1;   // ROM latency used by the bench ROM
  localparam int R = 16;  // history ring depth
  localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_PEND = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n, en, cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_fword;
  logic [7:0]  cfg_pword, cfg_amp;
  logic [1:0]  cfg_mode;
  logic [7:0]  rd_addr, rd_data, da_data;
  logic        da_clk, wrap_pulse;

  dds_wave_gen #(.ACC_W(32), .ADDR_W(8), .DATA_W(8), .ROM_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_fword(cfg_fword), .cfg_pword(cfg_pword), .cfg_amp(cfg_amp), .cfg_mode(cfg_mode),
    .rd_addr(rd_addr), .rd_data(rd_data), .da_clk(da_clk), .da_data(da_data),
    .wrap_pulse(wrap_pulse)
  );

  always #5 clk = ~clk;

  logic [7:0] rom [256];
  always @(posedge clk) rd_data <= rom[rd_addr];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model state
  logic [1:0]  m_state;
  logic [31:0] m_acc, act_f, sh_f;
  logic [7:0]  act_p, act_a, sh_p, sh_a, m_addr, m_da;
  logic [1:0]  act_m, sh_m;
  logic        m_wrap, m_accepted;
  logic [32:0] m_sum;
  bit          hv [R];
  bit          he [R];
  int          ha [R];
  int          hm [R];
  int          hamp [R];
  int          n = 100;

  function automatic int shape(input int a, input int md, input int romv);
    case (md)
      0:       return romv;
      1:       return (a >= 128) ? 255 : 0;
      2:       return a;
      default: return (a < 128) ? 2 * a : 511 - 2 * a;
    endcase
  endfunction

  function automatic int scale(input int smp, input int amp);
    int p, q;
    p = (smp - 128) * (amp + 1);
    q = (p >= 0) ? p / 256 : -((-p + 255) / 256);  // floor division
    return 128 + q;
  endfunction

  always @(posedge clk) begin
    bit upd, ok;
    int m;
    n++;
    if (!rst_n) begin
      m_state = S_IDLE; m_acc = 0;
      act_f = 0; act_p = 0; act_a = 8'hFF; act_m = 0;
      sh_f = 0; sh_p = 0; sh_a = 0; sh_m = 0;
      m_addr = 0; m_wrap = 0; m_da = 8'h80; m_accepted = 0;
      for (int k = 0; k < R; k++) begin hv[k] = 0; he[k] = 0; end
    end else begin
      m_accepted = cfg_valid && (m_state != S_PEND);
      upd   = (m_state != S_IDLE) && en;
      m_sum = {1'b0, m_acc} + {1'b0, act_f};
      hv[n % R] = upd;
      he[n % R] = en;
      if (upd) begin
        m_addr = 8'(m_acc[31:24] + act_p);
        ha[n % R] = m_addr; hm[n % R] = act_m; hamp[n % R] = act_a;
      end
      m_wrap = upd && m_sum[32];
      // Sample whose address was issued L+1 edges ago, provided en stayed high since.
      m = n - L - 1;
      ok = hv[m % R];
      for (int j = m + 1; j <= n; j++) ok = ok && he[j % R];
      m_da = ok ? 8'(scale(shape(ha[m % R], hm[m % R], rom[ha[m % R]]), hamp[m % R])) : 8'h80;
      case (m_state)
        S_IDLE: begin
          if (m_accepted) begin
            act_f = cfg_fword; act_p = cfg_pword; act_a = cfg_amp; act_m = cfg_mode; m_acc = 0;
          end
          if (en) m_state = S_RUN;
        end
        S_RUN: begin
          if (!en) begin
            if (m_accepted) begin
              act_f = cfg_fword; act_p = cfg_pword; act_a = cfg_amp; act_m = cfg_mode;
            end
            m_state = S_IDLE;
          end else begin
            m_acc = m_sum[31:0];
            if (m_accepted) begin
              sh_f = cfg_fword; sh_p = cfg_pword; sh_a = cfg_amp; sh_m = cfg_mode;
              m_state = S_PEND;
            end
          end
        end
        default: begin
          if (en) m_acc = m_sum[31:0];
          if (!en || m_sum[32]) begin
            act_f = sh_f; act_p = sh_p; act_a = sh_a; act_m = sh_m;
            m_state = en ? S_RUN : S_IDLE;
          end
        end
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    check("rd_addr", 32'(rd_addr), 32'(m_addr));
    check("da_data", 32'(da_data), 32'(m_da));
    check("wrap_pulse", 32'(wrap_pulse), 32'(m_wrap));
    check("cfg_ready", 32'(cfg_ready), 32'(m_state != S_PEND));
  endtask

  task automatic run(input int cycles);
    for (int k = 0; k < cycles; k++) tick();
  endtask

  task automatic send_cfg(input logic [31:0] f, input logic [7:0] p, input logic [7:0] a,
                          input logic [1:0] md);
    bit got = 0;
    cfg_valid = 1; cfg_fword = f; cfg_pword = p; cfg_amp = a; cfg_mode = md;
    for (int k = 0; k < 600 && !got; k++) begin
      tick();
      got = m_accepted;
    end
    cfg_valid = 0;
    check("cfg_accept", 32'(got), 32'd1);
    $display("cfg fword=%08h pword=%02h amp=%02h mode=%0d accepted=%0d", f, p, a, md, got);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) rom[k] = 8'($urandom);
    rst_n = 0; en = 0; cfg_valid = 0;
    cfg_fword = 0; cfg_pword = 0; cfg_amp = 0; cfg_mode = 0;
    run(3);
    rst_n = 1;
    run(2);

    en = 1;
    send_cfg(32'h0100_0000, 8'h00, 8'd255, 2'd2);   // ramp, one address per cycle
    run(300);
    send_cfg(32'h8000_0000, 8'h00, 8'd255, 2'd1);   // square at half rate
    run(300);
    send_cfg(32'h0100_0000, 8'h00, 8'd127, 2'd2);   // half amplitude ramp
    run(300);
    send_cfg(32'h0200_0000, 8'h00, 8'd255, 2'd2);   // deferred step change
    run(300);
    send_cfg(32'h00C0_0000, 8'h05, 8'd200, 2'd0);   // ROM playback
    run(200);
    en = 0;
    run(5);
    en = 1;
    run(50);
    rst_n = 0;
    run(2);
    rst_n = 1;
    en = 1;
    send_cfg(32'h0300_0000, 8'h40, 8'd90, 2'd3);
    run(150);

    for (int k = 0; k < 3000; k++) begin
      rst_n     = ($urandom_range(0, 599) != 0);
      en        = ($urandom_range(0, 15) != 0);
      cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_fword = ($urandom_range(0, 9) == 0) ? 32'h0 : ($urandom >> $urandom_range(0, 7));
      cfg_pword = 8'($urandom);
      cfg_amp   = 8'($urandom);
      cfg_mode  = 2'($urandom);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
